fft_out_serializer: RTL and testbench
=====================================

# fft_out_serializer

Output sequencer placed directly downstream of the 32-to-1 result multiplexer of the 16-point FFT. On a start pulse from the FFT core it sends a sync header byte, then walks the multiplexer select from 0 to NUM_WORDS-1. It registers each selected result word and streams it to the transmit interface (UART/host link) over a valid/ready handshake. It emits a one-cycle done pulse when the frame is complete.

## Interface
- DATA_LENGTH, 8, width of each result word and of tx_data; must equal the multiplexer DATA_LENGTH.
- NUM_WORDS, 32, result words per frame (16 bins × re/im); legal range 1..64.
- HEADER, 8'hA5, sync word sent before every frame; zero-extended or truncated to DATA_LENGTH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset; asserts asynchronously, releases synchronously to clk.
- start  in  1  frame request pulse from the FFT core; sampled only in IDLE.
- mux_data  in  DATA_LENGTH  output of the result multiplexer, selected by sel.
- sel  out  6  select driven to the multiplexer.
- tx_data  out  DATA_LENGTH  registered word presented downstream.
- tx_valid  out  1  tx_data is valid; held until accepted.
- tx_ready  in  1  downstream accepts when tx_valid && tx_ready at a rising edge.
- busy  out  1  frame in progress; the FFT core must hold its results stable while busy=1.
- done  out  1  one-cycle pulse after the last word is accepted.

## Operation
- Reset values: state=IDLE, sel=0, tx_data=0, tx_valid=0, busy=0, done=0.
- States:
  - IDLE: busy=0, sel=0. An edge with start=1 loads tx_data=HEADER, sets tx_valid=1 and busy=1, and moves to SEND_HDR.
  - SEND_HDR: hold tx_data and tx_valid. On accept, clear tx_valid, keep sel=0, and move to FETCH.
  - FETCH (exactly one cycle; sel has been stable for one full cycle): load tx_data=mux_data, set tx_valid=1, and move to SEND_WORD.
  - SEND_WORD: hold tx_data, tx_valid and sel.
    - On accept with sel < NUM_WORDS-1: sel+=1, tx_valid=0, go to FETCH.
    - On accept with sel = NUM_WORDS-1: sel=0, tx_valid=0, busy=0, done=1 for one cycle, go to IDLE.
- The sel counter is unsigned 6-bit. It never exceeds NUM_WORDS-1, so there is no wrap-around within a frame.
- While busy=1, start is ignored: no restart and no queued request.
- start on the same edge that done is asserted is ignored, because the state machine is not yet in IDLE. start on the next edge is honoured.
- tx_data, tx_valid and sel must not change while tx_valid=1 and tx_ready=0. Downstream stalls of any length are legal.
- Reset mid-frame aborts immediately: all outputs return to reset values, and no done pulse is generated.
- mux_data is sampled only in FETCH; its value in all other states is don't-care.

## Timing
- With start sampled at edge k and tx_ready held high:
  - Header is valid after edge k and accepted at edge k+1.
  - Word n is valid after edge k+2+2n and accepted at edge k+3+2n.
  - The last word (n=NUM_WORDS-1) is accepted at edge k+2·NUM_WORDS+1.
  - done is high, and busy is low, for the cycle after that edge.
- Default frame: 33 transfers, done at edge k+65.
- Throughput is one word per 2 cycles at best. Each cycle of tx_ready=0 while tx_valid=1 adds one cycle.
- sel to mux_data is purely combinational in the multiplexer. sel is stable for at least one full cycle before capture.

## Test plan
- Ready always high, mux_data = 8'h10+sel, start pulse at edge k:
  - Stream is A5, 10, 11, …, 2F.
  - done occurs at edge k+65; busy is high from k to k+65.
  - tx_valid pattern is 1,0,1,0 after the header.
- tx_ready low for 5 cycles while word 7 is valid: tx_data stays 17 and sel stays 7 throughout; the frame completes 5 cycles late with no lost or duplicated words.
- start pulses during busy (at word 3 and on the done edge): no restart; the stream is identical to the first test. A start one cycle after done begins a new frame with A5.
- rst_n low while word 12 is pending, then released: all outputs return to zero, no done pulse, state is IDLE. The next start yields a full, correct frame.
- NUM_WORDS=1, HEADER=8'h5A, mux_data=8'hC3: stream is 5A, C3; done at edge k+3; sel stays 0.
- Random tx_ready (50%) over 100 frames: scoreboard checks order and values, exactly one done per frame, and that tx_data never changes while tx_valid && !tx_ready.

Source files
------------

// File: rtl/fft_out_serializer.sv
// fft_out_serializer: frames FFT result words (header + NUM_WORDS words) onto a valid/ready link
//   clk, rst_n     : clock, async active-low reset
//   start          : frame request, sampled only when idle
//   mux_data / sel : result multiplexer data in / select out
//   tx_data/valid/ready : downstream handshake, held while stalled
//   busy / done    : frame in progress / one-cycle completion pulse
module fft_out_serializer #(
    parameter int         DATA_LENGTH = 8,
    parameter int         NUM_WORDS   = 32,
    parameter logic [7:0] HEADER      = 8'hA5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [DATA_LENGTH-1:0] mux_data,
    output logic [5:0]             sel,
    output logic [DATA_LENGTH-1:0] tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   busy,
    output logic                   done
);
    localparam logic [DATA_LENGTH-1:0] HDR  = DATA_LENGTH'(HEADER);
    localparam logic [5:0]             LAST = 6'(NUM_WORDS - 1);
    typedef enum logic [1:0] {IDLE, SEND_HDR, FETCH, SEND_WORD} state_t;
    state_t                 state_q, state_d;
    logic [5:0]             sel_q, sel_d;
    logic [DATA_LENGTH-1:0] tx_data_q, tx_data_d;
    logic                   tx_valid_q, tx_valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                tx_data_d  = HDR;
                tx_valid_d = 1'b1;
                busy_d     = 1'b1;
                state_d    = SEND_HDR;
            end
            SEND_HDR: if (tx_ready) begin
                tx_valid_d = 1'b0;
                state_d    = FETCH;
            end
            // sel settled during the previous cycle, so mux_data is safe to capture here
            FETCH: begin
                tx_data_d  = mux_data;
                tx_valid_d = 1'b1;
                state_d    = SEND_WORD;
            end
            SEND_WORD: if (tx_ready) begin
                tx_valid_d = 1'b0;
                sel_d      = (sel_q == LAST) ? 6'd0 : sel_q + 6'd1;
                busy_d     = (sel_q != LAST);
                done_d     = (sel_q == LAST);
                state_d    = (sel_q == LAST) ? IDLE : FETCH;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end
    assign sel      = sel_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
endmodule

// File: tb/tb_fft_out_serializer.sv
// tb_fft_out_serializer: randomized frame checks of fft_out_serializer against a stream model
module tb_fft_out_serializer;
    localparam int NW = 32;
    logic       clk = 1'b0;
    logic       rst_n, start, tx_ready, start1;
    logic [7:0] mux_data, tx_data, tx_data1;
    logic [5:0] sel, sel1;
    logic       tx_valid, busy, done, tx_valid1, busy1, done1;
    logic [7:0] mux_tab [64];
    logic [7:0] got[$], exp_q[$];
    int edge_cnt = 0;
    int n_checks = 0, n_fail = 0;
    int k_edge, done_edge, n_done, viol, busy_bad, low_valid, timeout;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;
    assign mux_data = mux_tab[sel];

    fft_out_serializer #(.DATA_LENGTH(8), .NUM_WORDS(NW), .HEADER(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mux_data(mux_data), .sel(sel),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done));

    fft_out_serializer #(.DATA_LENGTH(8), .NUM_WORDS(1), .HEADER(8'h5A)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .mux_data(8'hC3), .sel(sel1),
        .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(1'b1), .busy(busy1), .done(done1));

    task automatic build_exp(input logic [7:0] hdr, input int n);
        exp_q.delete();
        exp_q.push_back(hdr);
        for (int i = 0; i < n; i++) exp_q.push_back(mux_tab[i]);
    endtask

    function automatic int first_diff();
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            if (got[i] != exp_q[i]) return i;
        return (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    endfunction

    // Drives one frame from the idle state and records what crossed the link.
    task automatic run_frame(input int pct, input int stall_idx, input int stall_len, input bit poke);
        int rem = stall_len;
        bit prev_stall = 1'b0, fin = 1'b0;
        logic [7:0] pd = '0;
        logic [5:0] ps = '0;
        got.delete();
        n_done = 0; viol = 0; busy_bad = 0; low_valid = 0; timeout = 1; done_edge = -1;
        start = 1'b1;
        tx_ready = ($urandom_range(99) < pct);
        @(negedge clk);
        k_edge = edge_cnt;
        start = 1'b0;
        for (int c = 0; c < 3000 && !fin; c++) begin
            if (prev_stall && (tx_data !== pd || sel !== ps || tx_valid !== 1'b1)) viol++;
            if (done) begin
                n_done++; done_edge = edge_cnt; fin = 1'b1; timeout = 0;
                if (busy) busy_bad++;
            end else if (!busy) busy_bad++;
            if (!tx_valid && !done) low_valid++;
            if (tx_valid && rem > 0 && got.size() == stall_idx) begin
                tx_ready = 1'b0;
                rem--;
            end else tx_ready = ($urandom_range(99) < pct);
            start = poke && (done || (tx_valid && tx_ready && (got.size() == 4 || got.size() == NW)));
            prev_stall = tx_valid && !tx_ready;
            pd = tx_data;
            ps = sel;
            if (tx_valid && tx_ready) got.push_back(tx_data);
            @(negedge clk);
        end
        start = 1'b0;
        if (done) n_done++;
        tx_ready = 1'b1;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({sel, tx_data, tx_valid, busy, done} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_in: sel=%h data=%h v=%b busy=%b done=%b, required all 0", sel, tx_data, tx_valid, busy, done);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({sel, tx_data, tx_valid, busy, done, sel1, tx_data1, tx_valid1, busy1, done1} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_out: sel=%h data=%h v=%b busy=%b done=%b, required all 0", sel, tx_data, tx_valid, busy, done);
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 64; i++) mux_tab[i] = 8'h10 + 8'(i);
        build_exp(8'hA5, NW);
        run_frame(100, -1, 0, 1'b0);
        n_checks++;
        if (got != exp_q) begin
            n_fail++;
            $display("FAIL basic_stream: %0d words, differs at %0d, required %0d words", got.size(), first_diff(), exp_q.size());
        end
        n_checks++;
        if (done_edge !== k_edge + 2 * NW + 1) begin
            n_fail++;
            $display("FAIL basic_done_edge: got k+%0d, required k+%0d", done_edge - k_edge, 2 * NW + 1);
        end
        n_checks++;
        if (n_done !== 1 || busy_bad !== 0) begin
            n_fail++;
            $display("FAIL basic_done_busy: done pulses %0d busy errors %0d, required 1 and 0", n_done, busy_bad);
        end
        n_checks++;
        if (low_valid !== NW) begin
            n_fail++;
            $display("FAIL basic_valid_gaps: %0d idle cycles, required %0d", low_valid, NW);
        end
    endtask

    task automatic test_stall();
        build_exp(8'hA5, NW);
        run_frame(100, 8, 5, 1'b0);
        n_checks++;
        if (got != exp_q || viol !== 0) begin
            n_fail++;
            $display("FAIL stall_stream: %0d words diff at %0d, hold errors %0d, required %0d words and 0", got.size(), first_diff(), viol, exp_q.size());
        end
        n_checks++;
        if (done_edge !== k_edge + 2 * NW + 6 || n_done !== 1) begin
            n_fail++;
            $display("FAIL stall_done: edge k+%0d pulses %0d, required k+%0d and 1", done_edge - k_edge, n_done, 2 * NW + 6);
        end
    endtask

    task automatic test_busy_start();
        int seen = 0;
        build_exp(8'hA5, NW);
        run_frame(100, -1, 0, 1'b1);
        n_checks++;
        if (got != exp_q || n_done !== 1 || done_edge !== k_edge + 2 * NW + 1) begin
            n_fail++;
            $display("FAIL busy_start_stream: %0d words diff at %0d pulses %0d edge k+%0d, required %0d words 1 pulse k+%0d",
                     got.size(), first_diff(), n_done, done_edge - k_edge, exp_q.size(), 2 * NW + 1);
        end
        n_checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hA5 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_after_done: v=%b data=%h busy=%b, required 1 a5 1", tx_valid, tx_data, busy);
        end
        for (int c = 0; c < 200 && seen == 0; c++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        n_checks++;
        if (seen !== 1) begin
            n_fail++;
            $display("FAIL restart_drain: done seen %0d, required 1", seen);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int found = 0, dn = 0;
        for (int i = 0; i < 64; i++) mux_tab[i] = 8'(i * 7 + 3);
        start = 1'b1;
        tx_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 200 && found == 0; c++) begin
            if (tx_valid && sel == 6'd12 && tx_data == mux_tab[12]) found = 1;
            else @(negedge clk);
        end
        n_checks++;
        if (found !== 1) begin
            n_fail++;
            $display("FAIL reset_mid_reach: word 12 found %0d, required 1", found);
        end
        tx_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({sel, tx_data, tx_valid, busy, done} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_mid_async: sel=%h data=%h v=%b busy=%b, required all 0", sel, tx_data, tx_valid, busy);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) dn++;
        end
        rst_n = 1'b1;
        tx_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done || busy || tx_valid) dn++;
        end
        n_checks++;
        if (dn !== 0 || {sel, tx_data} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_mid_idle: stray activity %0d sel=%h data=%h, required 0", dn, sel, tx_data);
        end
        build_exp(8'hA5, NW);
        run_frame(100, -1, 0, 1'b0);
        n_checks++;
        if (got != exp_q || n_done !== 1) begin
            n_fail++;
            $display("FAIL reset_mid_refill: %0d words diff at %0d pulses %0d, required %0d words 1 pulse", got.size(), first_diff(), n_done, exp_q.size());
        end
    endtask

    task automatic test_single_word();
        int k1, d1 = -1, sel_bad = 0;
        logic [7:0] q1[$];
        start1 = 1'b1;
        @(negedge clk);
        k1 = edge_cnt;
        start1 = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (tx_valid1) q1.push_back(tx_data1);
            if (sel1 !== 6'd0) sel_bad++;
            if (done1) d1 = edge_cnt;
            @(negedge clk);
        end
        n_checks++;
        if (q1.size() != 2 || q1[0] !== 8'h5A || q1[1] !== 8'hC3) begin
            n_fail++;
            $display("FAIL single_stream: %0d words first %h, required 5a c3", q1.size(), (q1.size() > 0) ? q1[0] : 8'h00);
        end
        n_checks++;
        if (d1 !== k1 + 3 || sel_bad !== 0) begin
            n_fail++;
            $display("FAIL single_done: edge k+%0d sel errors %0d, required k+3 and 0", d1 - k1, sel_bad);
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 100; f++) begin
            for (int i = 0; i < 64; i++) mux_tab[i] = 8'($urandom);
            build_exp(8'hA5, NW);
            run_frame(50, -1, 0, 1'b0);
            n_checks++;
            if (got != exp_q || timeout !== 0) begin
                n_fail++;
                $display("FAIL rand_stream f%0d: %0d words diff at %0d timeout %0d, required %0d words", f, got.size(), first_diff(), timeout, exp_q.size());
            end
            n_checks++;
            if (n_done !== 1 || viol !== 0 || busy_bad !== 0) begin
                n_fail++;
                $display("FAIL rand_ctrl f%0d: pulses %0d hold errors %0d busy errors %0d, required 1 0 0", f, n_done, viol, busy_bad);
            end
            repeat ($urandom_range(2)) @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        start1 = 1'b0;
        tx_ready = 1'b0;
        for (int i = 0; i < 64; i++) mux_tab[i] = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_busy_start();
        test_reset_mid();
        test_single_word();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
